// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared widths, exception bundles, FSM states and cause codes for the writeback stage
package writeback_stage_pkg;
  localparam int PC_WIDTH = 32;
  localparam int REG_FILE_ADDR = 5;
  localparam int REG_FILE_DATA = 32;
  localparam int DCACHE_MAX_ACC_SIZE = 32;
  localparam logic [PC_WIDTH-1:0] XCPT_VECTOR_DEF = 32'h0000_2000;
  typedef struct packed {
    logic xcpt_bus_error;
    logic xcpt_itlb_miss;
    logic [31:0] addr;
    logic [PC_WIDTH-1:0] pc;
  } fetch_xcpt_t;
  typedef struct packed {
    logic xcpt_illegal_instr;
    logic [PC_WIDTH-1:0] pc;
  } decode_xcpt_t;
  typedef struct packed {
    logic xcpt_addr_fault;
    logic xcpt_fetch_dtlb_miss;
    logic [31:0] addr;
    logic [PC_WIDTH-1:0] pc;
  } cache_xcpt_t;
  typedef logic [1:0] wb_state_t;
  localparam wb_state_t ST_RUN = 2'd0;
  localparam wb_state_t ST_XCPT = 2'd1;
  localparam wb_state_t ST_HANDLER = 2'd2;
  localparam wb_state_t ST_HALT = 2'd3;
  typedef logic [3:0] xcpt_cause_t;
  localparam xcpt_cause_t CAUSE_NONE = 4'd0;
  localparam xcpt_cause_t CAUSE_BUS_ERROR = 4'd1;
  localparam xcpt_cause_t CAUSE_ITLB_MISS = 4'd2;
  localparam xcpt_cause_t CAUSE_ILLEGAL = 4'd3;
  localparam xcpt_cause_t CAUSE_ADDR_FAULT = 4'd4;
  localparam xcpt_cause_t CAUSE_DTLB_MISS = 4'd5;
endpackage

// File: rtl/writeback_if.sv
// writeback_if: cache-stage request/exception bundle in, RF write, redirect and machine state out
interface writeback_if import writeback_stage_pkg::*; #(parameter int CNT_W = 32);
  logic write_rf;
  logic [REG_FILE_ADDR-1:0] dest_rf;
  logic [DCACHE_MAX_ACC_SIZE-1:0] rsp_data;
  logic [PC_WIDTH-1:0] wb_instr_pc;
  fetch_xcpt_t xcpt_fetch;
  decode_xcpt_t xcpt_decode;
  cache_xcpt_t xcpt_cache;
  logic iret_valid;
  logic rf_wr_en;
  logic [REG_FILE_ADDR-1:0] rf_wr_addr;
  logic [REG_FILE_DATA-1:0] rf_wr_data;
  logic flush;
  logic redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic priv_mode;
  logic [PC_WIDTH-1:0] rm0;
  logic [31:0] rm1;
  logic [3:0] rm2;
  logic halted;
  logic [CNT_W-1:0] rf_wr_cnt;
  modport master (
    output write_rf, dest_rf, rsp_data, wb_instr_pc, xcpt_fetch, xcpt_decode, xcpt_cache, iret_valid,
    input rf_wr_en, rf_wr_addr, rf_wr_data, flush, redirect_valid, redirect_pc, priv_mode, rm0, rm1, rm2, halted, rf_wr_cnt
  );
  modport slave (
    input write_rf, dest_rf, rsp_data, wb_instr_pc, xcpt_fetch, xcpt_decode, xcpt_cache, iret_valid,
    output rf_wr_en, rf_wr_addr, rf_wr_data, flush, redirect_valid, redirect_pc, priv_mode, rm0, rm1, rm2, halted, rf_wr_cnt
  );
endinterface

// File: rtl/writeback_stage_xcpt_prio_enc.sv
// xcpt_prio_enc: picks the highest-priority pending exception and its pc/addr/cause
module xcpt_prio_enc import writeback_stage_pkg::*; (
  input  fetch_xcpt_t         fetch,
  input  decode_xcpt_t        decode,
  input  cache_xcpt_t         cache,
  output logic                valid,
  output xcpt_cause_t         cause,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         addr
);
  logic f_hit;
  always_comb begin
    f_hit = fetch.xcpt_bus_error | fetch.xcpt_itlb_miss;
    valid = f_hit | decode.xcpt_illegal_instr | cache.xcpt_addr_fault | cache.xcpt_fetch_dtlb_miss;
    cause = fetch.xcpt_bus_error ? CAUSE_BUS_ERROR :
            fetch.xcpt_itlb_miss ? CAUSE_ITLB_MISS :
            decode.xcpt_illegal_instr ? CAUSE_ILLEGAL :
            cache.xcpt_addr_fault ? CAUSE_ADDR_FAULT :
            cache.xcpt_fetch_dtlb_miss ? CAUSE_DTLB_MISS : CAUSE_NONE;
    pc = f_hit ? fetch.pc : decode.xcpt_illegal_instr ? decode.pc : cache.pc;
    // illegal_instr carries no data address
    addr = f_hit ? fetch.addr : decode.xcpt_illegal_instr ? '0 : cache.addr;
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: registers the RF write and runs the RUN/XCPT/HANDLER/HALT exception machine
module writeback_stage import writeback_stage_pkg::*; #(
  parameter logic [PC_WIDTH-1:0] XCPT_VECTOR = XCPT_VECTOR_DEF,
  parameter int CNT_W = 32
) (
  input logic clock,
  input logic reset,
  writeback_if.slave wb
);
  logic x_valid;
  xcpt_cause_t x_cause;
  logic [PC_WIDTH-1:0] x_pc;
  logic [31:0] x_addr;
  wb_state_t state_q, state_d;
  logic rf_wr_en_q, rf_wr_en_d, flush_q, flush_d, priv_q, priv_d, halted_q, halted_d;
  logic [REG_FILE_ADDR-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [REG_FILE_DATA-1:0] rf_wr_data_q, rf_wr_data_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d, rm0_q, rm0_d;
  logic [31:0] rm1_q, rm1_d;
  logic [3:0] rm2_q, rm2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic in_run, in_xcpt, in_hdl, take_xcpt, nest, do_iret;
  xcpt_prio_enc u_enc (
    .fetch(wb.xcpt_fetch), .decode(wb.xcpt_decode), .cache(wb.xcpt_cache),
    .valid(x_valid), .cause(x_cause), .pc(x_pc), .addr(x_addr)
  );
  always_comb begin
    in_run = state_q == ST_RUN;
    in_xcpt = state_q == ST_XCPT;
    in_hdl = state_q == ST_HANDLER;
    take_xcpt = in_run & x_valid;
    nest = in_hdl & x_valid;
    do_iret = in_hdl & wb.iret_valid & ~x_valid;
    state_d = take_xcpt ? ST_XCPT : in_xcpt ? ST_HANDLER : nest ? ST_HALT : do_iret ? ST_RUN : state_q;
    // XCPT-cycle inputs belong to flushed younger work, so they never commit
    rf_wr_en_d = (in_run | in_hdl) & ~x_valid & wb.write_rf;
    rf_wr_addr_d = wb.dest_rf;
    rf_wr_data_d = REG_FILE_DATA'(wb.rsp_data);
    cnt_d = cnt_q + CNT_W'(rf_wr_en_d);
    flush_d = take_xcpt | do_iret;
    redirect_pc_d = take_xcpt ? XCPT_VECTOR : do_iret ? rm0_q : '0;
    priv_d = take_xcpt ? 1'b1 : do_iret ? 1'b0 : priv_q;
    rm0_d = take_xcpt ? x_pc : rm0_q;
    rm1_d = take_xcpt ? x_addr : rm1_q;
    rm2_d = take_xcpt ? x_cause : rm2_q;
    halted_d = halted_q | nest;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= ST_RUN;
      rf_wr_en_q <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      cnt_q <= '0;
      flush_q <= 1'b0;
      redirect_pc_q <= '0;
      priv_q <= 1'b0;
      rm0_q <= '0;
      rm1_q <= '0;
      rm2_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rf_wr_en_q <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      cnt_q <= cnt_d;
      flush_q <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      priv_q <= priv_d;
      rm0_q <= rm0_d;
      rm1_q <= rm1_d;
      rm2_q <= rm2_d;
      halted_q <= halted_d;
    end
  assign wb.rf_wr_en = rf_wr_en_q;
  assign wb.rf_wr_addr = rf_wr_addr_q;
  assign wb.rf_wr_data = rf_wr_data_q;
  assign wb.flush = flush_q;
  assign wb.redirect_valid = flush_q;
  assign wb.redirect_pc = redirect_pc_q;
  assign wb.priv_mode = priv_q;
  assign wb.rm0 = rm0_q;
  assign wb.rm1 = rm1_q;
  assign wb.rm2 = rm2_q;
  assign wb.halted = halted_q;
  assign wb.rf_wr_cnt = cnt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors for RF commit, exception entry/return, nesting, reset and counter wrap
module tb_writeback_stage;
  import writeback_stage_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  writeback_if #(.CNT_W(4)) w ();
  writeback_stage #(.CNT_W(4)) dut (.clock(clock), .reset(reset), .wb(w));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    w.write_rf = 1'b0;
    w.dest_rf = '0;
    w.rsp_data = '0;
    w.wb_instr_pc = '0;
    w.xcpt_fetch = '0;
    w.xcpt_decode = '0;
    w.xcpt_cache = '0;
    w.iret_valid = 1'b0;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    idle();
    tick();
    tick();
    chk("rst_en", 32'(w.rf_wr_en), 0);
    chk("rst_flush", 32'(w.flush), 0);
    chk("rst_rv", 32'(w.redirect_valid), 0);
    chk("rst_rpc", w.redirect_pc, 0);
    chk("rst_priv", 32'(w.priv_mode), 0);
    chk("rst_rm2", 32'(w.rm2), 0);
    chk("rst_halt", 32'(w.halted), 0);
    chk("rst_cnt", 32'(w.rf_wr_cnt), 0);
    reset = 1'b1;
    w.write_rf = 1'b1; w.dest_rf = 5'd5; w.rsp_data = 32'hCAFE;
    tick();
    chk("t1_en", 32'(w.rf_wr_en), 1);
    chk("t1_addr", 32'(w.rf_wr_addr), 5);
    chk("t1_data", w.rf_wr_data, 32'hCAFE);
    chk("t1_cnt", 32'(w.rf_wr_cnt), 1);
    idle(); w.iret_valid = 1'b1;
    tick();
    chk("run_iret_en", 32'(w.rf_wr_en), 0);
    chk("run_iret_flush", 32'(w.flush), 0);
    chk("run_iret_priv", 32'(w.priv_mode), 0);
    idle();
    w.write_rf = 1'b1; w.dest_rf = 5'd7; w.rsp_data = 32'h1234;
    w.xcpt_cache.xcpt_addr_fault = 1'b1; w.xcpt_cache.pc = 32'h100; w.xcpt_cache.addr = 32'h33;
    tick();
    chk("t2_en", 32'(w.rf_wr_en), 0);
    chk("t2_flush", 32'(w.flush), 1);
    chk("t2_rv", 32'(w.redirect_valid), 1);
    chk("t2_rpc", w.redirect_pc, 32'h2000);
    chk("t2_rm0", w.rm0, 32'h100);
    chk("t2_rm1", w.rm1, 32'h33);
    chk("t2_rm2", 32'(w.rm2), 4);
    chk("t2_priv", 32'(w.priv_mode), 1);
    chk("t2_cnt", 32'(w.rf_wr_cnt), 1);
    idle(); w.write_rf = 1'b1; w.xcpt_fetch.xcpt_bus_error = 1'b1; w.xcpt_fetch.pc = 32'h999;
    tick();
    chk("xcpt_ign_en", 32'(w.rf_wr_en), 0);
    chk("xcpt_ign_flush", 32'(w.flush), 0);
    chk("xcpt_ign_rm2", 32'(w.rm2), 4);
    chk("xcpt_ign_halt", 32'(w.halted), 0);
    idle(); w.write_rf = 1'b1; w.dest_rf = 5'd9; w.rsp_data = 32'h55;
    tick();
    chk("hdl_en", 32'(w.rf_wr_en), 1);
    chk("hdl_data", w.rf_wr_data, 32'h55);
    chk("hdl_cnt", 32'(w.rf_wr_cnt), 2);
    idle(); w.iret_valid = 1'b1;
    tick();
    chk("iret_flush", 32'(w.flush), 1);
    chk("iret_rpc", w.redirect_pc, 32'h100);
    chk("iret_priv", 32'(w.priv_mode), 0);
    idle();
    w.xcpt_fetch.xcpt_itlb_miss = 1'b1; w.xcpt_fetch.pc = 32'h200; w.xcpt_fetch.addr = 32'h44;
    w.xcpt_decode.xcpt_illegal_instr = 1'b1; w.xcpt_decode.pc = 32'h300;
    tick();
    chk("t3_rm2", 32'(w.rm2), 2);
    chk("t3_rm0", w.rm0, 32'h200);
    chk("t3_rm1", w.rm1, 32'h44);
    chk("t3_halt", 32'(w.halted), 0);
    idle();
    tick();
    w.iret_valid = 1'b1;
    tick();
    chk("t3_iret_rpc", w.redirect_pc, 32'h200);
    chk("t3_iret_rv", 32'(w.redirect_valid), 1);
    chk("t3_iret_priv", 32'(w.priv_mode), 0);
    idle(); w.xcpt_decode.xcpt_illegal_instr = 1'b1; w.xcpt_decode.pc = 32'h400;
    tick();
    chk("t4_rm2", 32'(w.rm2), 3);
    chk("t4_rm0", w.rm0, 32'h400);
    chk("t4_rm1", w.rm1, 0);
    idle();
    tick();
    w.iret_valid = 1'b1;
    w.xcpt_cache.xcpt_fetch_dtlb_miss = 1'b1; w.xcpt_cache.pc = 32'h500; w.xcpt_cache.addr = 32'h66;
    tick();
    chk("t4_halt", 32'(w.halted), 1);
    chk("t4_flush", 32'(w.flush), 0);
    chk("t4_rm0_keep", w.rm0, 32'h400);
    chk("t4_rm2_keep", 32'(w.rm2), 3);
    chk("t4_priv", 32'(w.priv_mode), 1);
    idle(); w.write_rf = 1'b1; w.dest_rf = 5'd3;
    tick();
    chk("halt_en", 32'(w.rf_wr_en), 0);
    chk("halt_cnt", 32'(w.rf_wr_cnt), 2);
    idle(); w.iret_valid = 1'b1;
    tick();
    chk("halt_iret_rv", 32'(w.redirect_valid), 0);
    chk("halt_stay", 32'(w.halted), 1);
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    w.xcpt_fetch.xcpt_bus_error = 1'b1; w.xcpt_fetch.xcpt_itlb_miss = 1'b1;
    w.xcpt_fetch.pc = 32'h600; w.xcpt_fetch.addr = 32'h77;
    tick();
    chk("t5_flush", 32'(w.flush), 1);
    chk("t5_rm2", 32'(w.rm2), 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_flush_drop", 32'(w.flush), 0);
    chk("t5_rv_drop", 32'(w.redirect_valid), 0);
    chk("t5_rpc", w.redirect_pc, 0);
    chk("t5_rm0", w.rm0, 0);
    chk("t5_priv", 32'(w.priv_mode), 0);
    chk("t5_halt", 32'(w.halted), 0);
    idle();
    tick();
    reset = 1'b1;
    w.write_rf = 1'b1; w.dest_rf = 5'd1;
    for (int i = 0; i < 15; i++) begin
      w.rsp_data = 32'(i);
      tick();
    end
    chk("t6_cnt15", 32'(w.rf_wr_cnt), 15);
    chk("t6_data", w.rf_wr_data, 14);
    tick();
    chk("t6_wrap", 32'(w.rf_wr_cnt), 0);
    idle();
    tick();
    chk("t6_hold", 32'(w.rf_wr_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
